ram_fifo_ctrl: RTL and testbench

//  Sequencer that drives the single-port 8x16 RAM (ram_8x16) as a first-in first-out (FIFO) buffer.
//  - Upstream side: valid/ready producer interface.
//  - Downstream side: valid/ready consumer interface.
//  - Arbitrates the shared addr/cs/rw port between pushes and head prefetches; at most one RAM access per cycle.
//  - Holds the head word in an output register, so the RAM read path never reaches the consumer.

---
 rtl/ram_fifo_ctrl_if.sv | 22 ++
 rtl/ram_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer valid-ready stream pair around the RAM-backed FIFO.
// The controller uses the slave modport; the traffic source/sink uses master.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer over a single-port RAM with a registered head word; an empty push shows next cycle.
// One RAM access per cycle: head refill (READ) beats a push, so in_ready drops on refill cycles.
module ram_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    ram_fifo_ctrl_if.slave    strm,
    output logic [ADDR_W:0]   level,
    output logic              ram_full,
    output logic              ram_cs,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_READ,
        OP_BYPASS,
        OP_WRITE,
        OP_HOLD
    } op_t;

    op_t               op;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt, ram_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              pop, slot, ram_empty;
    logic              in_ready_c;

    assign pop       = out_valid_q & strm.out_ready;
    assign slot      = ~out_valid_q | pop;
    assign ram_empty = (ram_cnt == '0);
    assign ram_full  = (ram_cnt == CNT_MAX);

    // Operation select; while reset is held nothing is allowed to touch the RAM.
    always_comb begin
        op = OP_IDLE;
        if (!rst) begin
            if (flush)                 op = OP_FLUSH;
            else if (slot && !ram_empty) op = OP_READ;
            else if (slot)             op = OP_BYPASS;
            else if (!ram_full)        op = OP_WRITE;
            else                       op = OP_HOLD;
        end
    end

    always_comb begin
        ram_cs      = 1'b0;
        ram_rw      = 1'b0;
        in_ready_c  = 1'b0;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        ram_cnt_d   = ram_cnt;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (op)
            OP_FLUSH: begin
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                ram_cnt_d   = '0;
                out_valid_d = 1'b0;
            end
            OP_READ: begin
                ram_cs      = 1'b1;
                out_data_d  = ram_dout;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr + 1'b1;
                ram_cnt_d   = ram_cnt - 1'b1;
            end
            OP_BYPASS: begin
                in_ready_c  = 1'b1;
                out_valid_d = strm.in_valid;
                if (strm.in_valid) out_data_d = strm.in_data;
            end
            OP_WRITE: begin
                in_ready_c = 1'b1;
                ram_cs     = strm.in_valid;
                ram_rw     = strm.in_valid;
                if (strm.in_valid) begin
                    wr_ptr_d  = wr_ptr + 1'b1;
                    ram_cnt_d = ram_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Idle RAM port parks on the read pointer.
    assign ram_addr = ram_rw ? wr_ptr : rd_ptr;
    assign ram_din  = strm.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            ram_cnt     <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign level          = ram_cnt + {{ADDR_W{1'b0}}, out_valid_q};

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 8x16 single-port RAM.
module tb_ram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  level;
    logic        ram_full, ram_cs, ram_rw;
    logic [2:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic [15:0] mem [8];

    int total = 0;
    int bad   = 0;

    ram_fifo_ctrl_if #(.DATA_W(16)) bus ();

    ram_fifo_ctrl #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .strm(bus),
        .level(level), .ram_full(ram_full), .ram_cs(ram_cs), .ram_rw(ram_rw),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_cs && ram_rw) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] q [$];
        logic [15:0] exp_w;
        int sent, got;
        logic orr, wr7, rd7, wrap_w, wrap_r;

        // T1: reset with garbage inputs
        rst = 1'b1; flush = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'($urandom);
        bus.out_ready = 1'($urandom);
        #3;
        chk("t1_ovalid", bus.out_valid, 0);
        chk("t1_irdy",   bus.in_ready,  0);
        chk("t1_cs",     ram_cs,        0);
        chk("t1_level",  level,         0);
        next_cycle();
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t1_irdy_rel", bus.in_ready, 1);

        // T2: bypass into empty FIFO
        next_cycle();
        bus.in_valid = 1'b1; bus.in_data = 16'hABCD;
        @(negedge clk);
        chk("t2_cs", ram_cs, 0);
        chk("t2_irdy", bus.in_ready, 1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_ovalid", bus.out_valid, 1);
        chk("t2_odata",  bus.out_data,  16'hABCD);
        chk("t2_level",  level,         1);
        chk("t2_cs_b",   ram_cs,        0);
        next_cycle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_cs_pop", ram_cs, 0);
        next_cycle();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t2_level_drained", level, 0);

        // T3: fill with 1..9, word 10 held
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            bus.in_valid = 1'b1; bus.in_data = 16'(k);
            @(negedge clk);
            chk("t3_irdy", bus.in_ready, 1);
            chk("t3_cs", ram_cs, (k == 1) ? 0 : 1);
            if (k > 1) begin
                chk("t3_rw",   ram_rw,   1);
                chk("t3_addr", ram_addr, k - 2);
            end
        end
        next_cycle();
        bus.in_data = 16'd10;
        @(negedge clk);
        chk("t3_full",  ram_full,     1);
        chk("t3_level", level,        9);
        chk("t3_irdy0", bus.in_ready, 0);
        chk("t3_cs0",   ram_cs,       0);

        // T4: drain in order; word 10 enters through bypass
        next_cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_ovalid", bus.out_valid, 1);
            chk("t4_odata",  bus.out_data,  i + 1);
            chk("t4_cs",     ram_cs,        1);
            chk("t4_rw",     ram_rw,        0);
            chk("t4_addr",   ram_addr,      i);
            chk("t4_irdy",   bus.in_ready,  0);
            chk("t4_level",  level,         9 - i);
            next_cycle();
        end
        @(negedge clk);
        chk("t4_odata9",  bus.out_data, 9);
        chk("t4_level9",  level,        1);
        chk("t4_irdy9",   bus.in_ready, 1);
        chk("t4_cs9",     ram_cs,       0);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_odata10", bus.out_data, 10);
        chk("t4_level10", level,        1);
        next_cycle();
        @(negedge clk);
        chk("t4_level0",  level,         0);
        chk("t4_ovalid0", bus.out_valid, 0);

        // T5: 20-word stream, consumer toggling
        next_cycle();
        sent = 0; got = 0; orr = 1'b0;
        wr7 = 1'b0; rd7 = 1'b0; wrap_w = 1'b0; wrap_r = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            orr = ~orr;
            bus.out_ready = orr;
            bus.in_valid  = (sent < 20);
            bus.in_data   = 16'h0100 + 16'(sent);
            @(negedge clk);
            chk("t5_level", level, q.size());
            chk("t5_irdy_vs_read", bus.in_ready, !(ram_cs && !ram_rw));
            if (ram_cs && ram_rw) begin
                if (wr7 && ram_addr == 3'd0) wrap_w = 1'b1;
                wr7 = (ram_addr == 3'd7);
            end
            if (ram_cs && !ram_rw) begin
                if (rd7 && ram_addr == 3'd0) wrap_r = 1'b1;
                rd7 = (ram_addr == 3'd7);
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
                chk("t5_order", bus.out_data, exp_w);
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                sent++;
            end
            next_cycle();
        end
        chk("t5_got",    got,    20);
        chk("t5_wrap_w", wrap_w, 1);
        chk("t5_wrap_r", wrap_r, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_level0", level, 0);

        // T6: flush at level 5, then bypass
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.in_valid = 1'b1; bus.in_data = 16'h0050 + 16'(k);
            @(negedge clk);
            chk("t6_irdy", bus.in_ready, 1);
        end
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_level5", level, 5);
        next_cycle();
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h0055; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_cs_fl",   ram_cs,       0);
        chk("t6_irdy_fl", bus.in_ready, 0);
        next_cycle();
        flush = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_ovalid0", bus.out_valid, 0);
        chk("t6_level0",  level,         0);
        chk("t6_irdy_bp", bus.in_ready,  1);
        chk("t6_cs_bp",   ram_cs,        0);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_odata",  bus.out_data,  16'h0055);
        chk("t6_ovalid", bus.out_valid, 1);
        chk("t6_level1", level,         1);

        // Async reset mid-cycle clears immediately
        next_cycle();
        #1 rst = 1'b1;
        #1;
        chk("ar_ovalid", bus.out_valid, 0);
        chk("ar_level",  level,         0);
        chk("ar_irdy",   bus.in_ready,  0);
        next_cycle();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
